// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with shadowed configuration.
// Each channel divides fin by a ratio D and stays high for H cycles at the end of every period.
module prog_clock_divider #(
  parameter int W       = 8,
  parameter int NCH     = 2,
  parameter int DEF_DIV = 8,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           fin,
  input  logic           reset,
  input  logic           en,
  input  logic           sync,
  input  logic           cfg_wr,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_div,
  input  logic [W-1:0]   cfg_high,
  output logic [NCH-1:0] fout,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pending,
  output logic           cfg_err
);

  logic [W-1:0]   cnt      [NCH];
  logic [W-1:0]   div_act  [NCH];
  logic [W-1:0]   high_act [NCH];
  logic [W-1:0]   div_sh   [NCH];
  logic [W-1:0]   high_sh  [NCH];

  logic [W-1:0]   cnt_n    [NCH];
  logic [W-1:0]   div_n    [NCH];
  logic [W-1:0]   high_n   [NCH];
  logic [W-1:0]   div_sh_n [NCH];
  logic [W-1:0]   high_sh_n[NCH];
  logic [NCH-1:0] pend_n;
  logic [NCH-1:0] fout_n;
  logic [NCH-1:0] wrap;
  logic           wr_ok;

  always_comb begin
    wr_ok = cfg_wr && (32'(cfg_ch) < NCH) && (cfg_div >= W'(2)) &&
            (cfg_high != '0) && (cfg_high < cfg_div);
    for (int i = 0; i < NCH; i++) begin
      wrap[i]      = en && (cnt[i] == div_act[i] - W'(1));
      cnt_n[i]     = cnt[i];
      div_n[i]     = div_act[i];
      high_n[i]    = high_act[i];
      div_sh_n[i]  = div_sh[i];
      high_sh_n[i] = high_sh[i];
      pend_n[i]    = pending[i];
      // sync outranks wrap; both restart the period and promote any pending shadow
      if (sync || wrap[i]) begin
        cnt_n[i] = '0;
        if (pending[i]) begin
          div_n[i]  = div_sh[i];
          high_n[i] = high_sh[i];
          pend_n[i] = 1'b0;
        end
      end else if (en) begin
        cnt_n[i] = cnt[i] + W'(1);
      end
      // a write landing in the apply cycle stays pending for the next boundary
      if (wr_ok && (cfg_ch == CW'(i))) begin
        div_sh_n[i]  = cfg_div;
        high_sh_n[i] = cfg_high;
        pend_n[i]    = 1'b1;
      end
      fout_n[i] = (cnt_n[i] >= div_n[i] - high_n[i]);
    end
  end

  assign tick = wrap;

  always_ff @(posedge fin) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]      <= '0;
        div_act[i]  <= W'(DEF_DIV);
        high_act[i] <= W'(DEF_DIV / 2);
        div_sh[i]   <= W'(DEF_DIV);
        high_sh[i]  <= W'(DEF_DIV / 2);
      end
      pending <= '0;
      fout    <= '0;
      cfg_err <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]      <= cnt_n[i];
        div_act[i]  <= div_n[i];
        high_act[i] <= high_n[i];
        div_sh[i]   <= div_sh_n[i];
        high_sh[i]  <= high_sh_n[i];
      end
      pending <= pend_n;
      fout    <= fout_n;
      cfg_err <= cfg_wr && !wr_ok;
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider (W=8, NCH=3, DEF_DIV=8).
module tb_prog_clock_divider;

  logic       fin = 1'b0;
  logic       reset, en, sync, cfg_wr;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div, cfg_high;
  logic [2:0] fout, tick, pending;
  logic       cfg_err;

  int vectors = 0;
  int miscompares = 0;

  prog_clock_divider #(.W(8), .NCH(3), .DEF_DIV(8)) dut (
    .fin(fin), .reset(reset), .en(en), .sync(sync),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high),
    .fout(fout), .tick(tick), .pending(pending), .cfg_err(cfg_err)
  );

  always #5 fin = ~fin;

  task automatic step();
    @(posedge fin);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; sync = 1'b0; cfg_wr = 1'b0;
    step();
    reset = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; sync = 1'b0; cfg_wr = 1'b0;
    cfg_ch = 2'd0; cfg_div = 8'd8; cfg_high = 8'd4;
    step(); step(); step();
    // leave ch1 with a pending shadow D=3,H=1, then reset while everything is active
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3; cfg_high = 8'd1;
    step();
    cfg_wr = 1'b0;
    vectors++;
    if (pending !== 3'b010) begin miscompares++; $display("FAIL pre_reset_pending: got %b expected %b", pending, 3'b010); end
    reset = 1'b1; sync = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd9; cfg_high = 8'd8;
    step();
    cfg_wr = 1'b0; sync = 1'b0;
    vectors++;
    if (fout !== 3'b000) begin miscompares++; $display("FAIL reset_fout: got %b expected %b", fout, 3'b000); end
    vectors++;
    if (pending !== 3'b000) begin miscompares++; $display("FAIL reset_pending: got %b expected %b", pending, 3'b000); end
    vectors++;
    if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_err: got %b expected %b", cfg_err, 1'b0); end
    reset = 1'b0; en = 1'b1;
    vectors++;
    if (tick !== 3'b000) begin miscompares++; $display("FAIL reset_tick: got %b expected %b", tick, 3'b000); end
    // sync right after reset must not resurrect the discarded D=3 shadow
    sync = 1'b1;
    step();
    sync = 1'b0;
    step(); step();
    vectors++;
    if (fout !== 3'b000) begin miscompares++; $display("FAIL reset_discard_shadow: got %b expected %b", fout, 3'b000); end
  endtask

  task automatic test_default();
    logic [15:0] f_pat = 16'b1111000011110000;
    logic [15:0] t_pat = 16'b1000000010000000;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (fout !== {3{f_pat[k]}}) begin miscompares++; $display("FAIL default_fout k=%0d: got %b expected %b", k, fout, {3{f_pat[k]}}); end
      vectors++;
      if (tick !== {3{t_pat[k]}}) begin miscompares++; $display("FAIL default_tick k=%0d: got %b expected %b", k, tick, {3{t_pat[k]}}); end
      step();
    end
  endtask

  task automatic test_write();
    logic [2:0] ef [14] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000,
                           3'b010, 3'b111, 3'b101, 3'b101, 3'b101, 3'b010, 3'b010};
    logic [2:0] et [14] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000,
                           3'b000, 3'b010, 3'b000, 3'b000, 3'b101, 3'b000, 3'b010};
    do_reset();
    step(); step(); step();
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5; cfg_high = 8'd2;
    step();
    cfg_wr = 1'b0;
    vectors++;
    if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL write_cfg_err: got %b expected %b", cfg_err, 1'b0); end
    for (int k = 0; k < 14; k++) begin
      vectors++;
      if (fout !== ef[k]) begin miscompares++; $display("FAIL write_fout k=%0d: got %b expected %b", k, fout, ef[k]); end
      vectors++;
      if (tick !== et[k]) begin miscompares++; $display("FAIL write_tick k=%0d: got %b expected %b", k, tick, et[k]); end
      vectors++;
      if (pending !== ((k < 4) ? 3'b010 : 3'b000)) begin
        miscompares++; $display("FAIL write_pending k=%0d: got %b expected %b", k, pending, (k < 4) ? 3'b010 : 3'b000);
      end
      step();
    end
  endtask

  task automatic test_bad_write();
    logic [1:0] bch  [4] = '{2'd0, 2'd1, 2'd1, 2'd3};
    logic [7:0] bdiv [4] = '{8'd1, 8'd5, 8'd5, 8'd5};
    logic [7:0] bhi  [4] = '{8'd1, 8'd0, 8'd5, 8'd2};
    int c = 0;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      cfg_wr = 1'b1; cfg_ch = bch[j]; cfg_div = bdiv[j]; cfg_high = bhi[j];
      step(); c++;
      cfg_wr = 1'b0;
      vectors++;
      if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL bad_err_pulse j=%0d: got %b expected %b", j, cfg_err, 1'b1); end
      vectors++;
      if (pending !== 3'b000) begin miscompares++; $display("FAIL bad_pending j=%0d: got %b expected %b", j, pending, 3'b000); end
      vectors++;
      if (fout !== ((c % 8 >= 4) ? 3'b111 : 3'b000)) begin
        miscompares++; $display("FAIL bad_fout j=%0d: got %b expected %b", j, fout, (c % 8 >= 4) ? 3'b111 : 3'b000);
      end
      step(); c++;
      vectors++;
      if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL bad_err_clear j=%0d: got %b expected %b", j, cfg_err, 1'b0); end
    end
  endtask

  task automatic test_enable();
    do_reset();
    for (int k = 0; k < 5; k++) step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (fout !== 3'b111) begin miscompares++; $display("FAIL hold_fout k=%0d: got %b expected %b", k, fout, 3'b111); end
      vectors++;
      if (tick !== 3'b000) begin miscompares++; $display("FAIL hold_tick k=%0d: got %b expected %b", k, tick, 3'b000); end
    end
    en = 1'b1;
    step(); step();
    vectors++;
    if (tick !== 3'b111) begin miscompares++; $display("FAIL resume_tick: got %b expected %b", tick, 3'b111); end
    step();
    vectors++;
    if (fout !== 3'b000) begin miscompares++; $display("FAIL resume_wrap_fout: got %b expected %b", fout, 3'b000); end
  endtask

  task automatic test_sync();
    logic [2:0] ef [6] = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b101, 3'b111};
    logic [2:0] et [6] = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b010};
    do_reset();
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3; cfg_high = 8'd1;
    step();
    cfg_wr = 1'b0;
    for (int k = 0; k < 4; k++) step();
    vectors++;
    if (fout !== 3'b111) begin miscompares++; $display("FAIL presync_fout: got %b expected %b", fout, 3'b111); end
    // same-cycle write to ch2 must be captured, not applied
    sync = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3; cfg_high = 8'd1;
    step();
    sync = 1'b0; cfg_wr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (fout !== ef[k]) begin miscompares++; $display("FAIL sync_fout k=%0d: got %b expected %b", k, fout, ef[k]); end
      vectors++;
      if (tick !== et[k]) begin miscompares++; $display("FAIL sync_tick k=%0d: got %b expected %b", k, tick, et[k]); end
      vectors++;
      if (pending !== 3'b100) begin miscompares++; $display("FAIL sync_pending k=%0d: got %b expected %b", k, pending, 3'b100); end
      step();
    end
  endtask

  task automatic test_long();
    do_reset();
    for (int k = 0; k < 7; k++) step();
    vectors++;
    if (tick[0] !== 1'b1) begin miscompares++; $display("FAIL long_wrapcycle_tick: got %b expected %b", tick[0], 1'b1); end
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd255; cfg_high = 8'd1;
    step();
    cfg_wr = 1'b0;
    vectors++;
    if (pending !== 3'b001) begin miscompares++; $display("FAIL long_pending_after_wrap: got %b expected %b", pending, 3'b001); end
    for (int k = 0; k < 7; k++) step();
    vectors++;
    if (tick[0] !== 1'b1) begin miscompares++; $display("FAIL long_old_period_tick: got %b expected %b", tick[0], 1'b1); end
    step();
    vectors++;
    if (pending !== 3'b000) begin miscompares++; $display("FAIL long_pending_applied: got %b expected %b", pending, 3'b000); end
    for (int n = 0; n < 510; n++) begin
      vectors++;
      if (fout[0] !== (n % 255 == 254)) begin
        miscompares++; $display("FAIL long_fout n=%0d: got %b expected %b", n, fout[0], (n % 255 == 254));
      end
      vectors++;
      if (tick[0] !== (n % 255 == 254)) begin
        miscompares++; $display("FAIL long_tick n=%0d: got %b expected %b", n, tick[0], (n % 255 == 254));
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sync = 1'b0; cfg_wr = 1'b0;
    cfg_ch = 2'd0; cfg_div = 8'd0; cfg_high = 8'd0;
    step();
    test_reset();
    test_default();
    test_write();
    test_bad_write();
    test_enable();
    test_sync();
    test_long();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter W, default 8: counter and config width.
REQ-002 SHALL have parameter NCH, default 2: number of independent divider channels, range 1..16.
REQ-003 SHALL have parameter DEF_DIV, default 8: divide ratio after reset, legal range 2..2^W-1.
REQ-004 SHALL have port fin, input, 1: the single clock; all logic on its rising edge only.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: global count enable.
REQ-007 SHALL have port sync, input, 1: restarts all channels together.
REQ-008 SHALL have port cfg_wr, input, 1: config write strobe, one write per cycle.
REQ-009 SHALL have port cfg_ch, input, max(1,$clog2(NCH)): target channel.
REQ-010 SHALL have port cfg_div, input, W: requested divide ratio D.
REQ-011 SHALL have port cfg_high, input, W: requested high time H, in fin cycles.
REQ-012 SHALL have port fout, output, NCH: divided clocks, registered.
REQ-013 SHALL have port tick, output, NCH: end-of-period strobes.
REQ-014 SHALL have port pending, output, NCH: shadow config not yet applied.
REQ-015 SHALL have port cfg_err, output, 1: rejected-write strobe, registered.

Function
REQ-016 Each channel SHALL hold cnt (W bits), active div_act/high_act and shadow div_sh/high_sh.
REQ-017 With en=1, cnt SHALL count 0..div_act-1 and then wrap to 0; with en=0, cnt, fout, pending SHALL hold.
REQ-018 At every edge, fout[i] SHALL equal (cnt[i] >= div_act[i]-high_act[i]); each period is low first, then high.
REQ-019 tick[i] SHALL be 1 exactly when en=1 and cnt[i]==div_act[i]-1; it is a decode of registered state and en.
REQ-020 A write SHALL be valid iff cfg_ch<NCH, cfg_div>=2, 1<=cfg_high<=cfg_div-1.
REQ-021 A valid write SHALL load div_sh/high_sh of cfg_ch and set pending[cfg_ch] on the next edge; outputs unchanged until applied.
REQ-022 An invalid write SHALL change no state except cfg_err=1 for exactly the following cycle.
REQ-023 A second valid write before apply SHALL overwrite the shadow; last write wins.
REQ-024 On a wrap of channel i with pending[i]=1, div_act/high_act SHALL load shadow, cnt=0, pending[i]=0, on the same edge.
REQ-025 A valid write to channel i in its wrap cycle SHALL NOT apply at that wrap; it applies at the next wrap or sync, and pending[i]=1 afterwards.
REQ-026 sync=1 SHALL, regardless of en, set all cnt=0, apply all pending shadows, and clear pending; fout SHALL follow REQ-018 next cycle.
REQ-027 sync SHALL take priority over wrap; a cfg_wr in the sync cycle SHALL be captured as pending, not applied.
REQ-028 Arithmetic SHALL be W-bit unsigned without overflow; div=2^W-1 with high=1 or high=div-1 SHALL operate correctly.
REQ-029 Channels SHALL be fully independent, except for the shared en, sync and config bus.

Reset
REQ-030 On reset=1, the next edge SHALL set cnt=0, div_act=div_sh=DEF_DIV, and high_act=high_sh=DEF_DIV/2 on all channels.
REQ-031 The same edge SHALL set pending=0, cfg_err=0, and fout=0; reset SHALL override en, sync and cfg_wr.
REQ-032 Reset mid-period or with pending set SHALL discard shadow writes and restart from defaults.

Verification
REQ-033 Reset, en=1, DEF_DIV=8 -> each fout 4 cycles 0 then 4 cycles 1, repeating; tick high at cnt=7, every 8 cycles.
REQ-034 Write ch1 D=5,H=2 at ch1 cnt=3 -> pending[1]=1 until ch1 wrap; ch1 finishes 8-cycle period, then 3 low/2 high; ch0 unaffected.
REQ-035 Write D=1, then H=0, then H=D, then cfg_ch=NCH -> each gives a one-cycle cfg_err pulse; pending and all outputs unchanged.
REQ-036 Drop en for 3 cycles at cnt=5 -> cnt, fout hold, tick stays 0; resumes at cnt=5.
REQ-037 sync at ch0 cnt=5 with ch1 pending D=3,H=1 -> next cycle all cnt=0, fout=0, ch1 pattern 2 low/1 high, pending=0.
REQ-038 Write ch0 D=255,H=1 (W=8) in ch0 wrap cycle -> applied one period later; then 254 low/1 high, tick every 255 cycles.
